alu_serial_seq: RTL and testbench
=================================

# alu_serial_seq

Bit-serial sequencer for the ALU datapath. It accepts a WIDTH-bit operation request and drives the external `one_bit_alu` slice LSB-first, one bit per clock. It carries the ripple carry in a flop and resolves SLT in a one-cycle fix-up step. It returns the result and flags over a valid/ready response channel, so the design needs only one 1-bit slice instead of a WIDTH-wide ripple array.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; legal range is 2 or more.

Ports:
- `clk`: input, 1 bit. Single clock for the block.
- `rst_n`: input, 1 bit. Reset, asynchronous assert, active-low.
- `req_valid`: input, 1 bit. A request is presented.
- `req_ready`: output, 1 bit. The block can accept a request.
- `req_op`: input, 4 bits. ALU op code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- `req_a`: input, WIDTH bits. Operand A.
- `req_b`: input, WIDTH bits. Operand B.
- `rsp_valid`: output, 1 bit. The response is valid.
- `rsp_ready`: input, 1 bit. The consumer accepts the response.
- `rsp_result`: output, WIDTH bits. Result.
- `rsp_zero`: output, 1 bit. `rsp_result` is 0.
- `rsp_carry`: output, 1 bit. Carry out of the MSB (ADD/SUB/SLT), else 0.
- `rsp_ovf`: output, 1 bit. Signed overflow (ADD/SUB/SLT), else 0.
- `alu_op`: output, 4 bits. Op driven to the slice.
- `alu_a`: output, 1 bit. Current A bit.
- `alu_b`: output, 1 bit. Current B bit.
- `alu_cin`: output, 1 bit. Carry into the slice.
- `alu_less`: output, 1 bit. Less input to the slice; always 0.
- `alu_sub`: output, 1 bit. 1 for SUB/SLT.
- `alu_r`: input, 1 bit. Slice result bit.
- `alu_cout`: input, 1 bit. Slice carry out.
- `alu_set`: input, 1 bit. Slice set output; sampled at the MSB only.

## Operation
- States are IDLE, RUN, FIX and DONE.
- `req_ready` equals 1 only in IDLE. `rsp_valid` equals 1 only in DONE.
- **IDLE:** on `req_valid` and `req_ready`:
  - latch `op`, A and B into shift registers;
  - clear the bit counter `idx` ($clog2(WIDTH) bits) and the result register;
  - go to RUN.
- **RUN:** one bit per cycle.
  - `alu_a` = A_sh[0], `alu_b` = B_sh[0], `alu_op` = latched op.
  - `alu_cin` = `alu_sub` when `idx`==0, else `carry_q`.
  - Each cycle: `carry_q` <= `alu_cout`; result shifts right with `alu_r` entering at the MSB; A_sh and B_sh shift right.
  - At `idx`==WIDTH-1:
    - `set_q` <= `alu_set`;
    - `ovf_q` <= `alu_cin` ^ `alu_cout` (forced to 0 for non-arithmetic ops);
    - `carry_q` <= `alu_cout` (forced to 0 for non-arithmetic ops);
    - next state is FIX if op==SLT, else DONE.
  - Otherwise `idx` increments.
- **FIX (SLT only, 1 cycle):**
  - result <= {WIDTH-1 zeros, `set_q` ^ `ovf_q`}, giving the correct signed less-than under overflow;
  - next state DONE.
- **DONE:** outputs hold stable until `rsp_ready`, then go to IDLE.
- Unsupported op codes run the full RUN sequence. The result is forced to 0, `rsp_zero`=1, carry and ovf are 0. No error is signalled.
- `rsp_zero` is registered, computed when entering DONE.
- Slice outputs outside RUN: all `alu_*` outputs are 0 except `alu_op`, which holds the latched op.
- Arithmetic wraps modulo 2^WIDTH. SUB carry follows the two's-complement convention: `rsp_carry`=1 means no borrow.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, all flags 0, all `alu_*`=0.
- Latency from the accepting edge to the first cycle with `rsp_valid`=1:
  - WIDTH+1 cycles for non-SLT ops (33 at the default);
  - WIDTH+2 cycles for SLT (34).
- Throughput: the DONE-to-IDLE transition costs one bubble. The next request can be accepted no earlier than the cycle after the response handshake.
- `rsp_ready` held at 0: DONE persists indefinitely and the outputs do not change.
- `req_valid` while busy: ignored; the request must be held by the producer.
- `rsp_ready` asserted in the same cycle `rsp_valid` rises: the handshake completes that edge.
- Reset mid-RUN or mid-FIX: the operation is aborted immediately. No response is produced; registers return to reset values.
- `alu_*` outputs are registered-state-driven combinational. The slice path (`alu_cout` to `carry_q`) must close within one cycle.

## Structure
- Shared header `alu_defs.vh` holds:
  - op-code constants `ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6, `ALU_SLT`=7, `ALU_NOR`=12;
  - state encodings.
- `one_bit_alu` is instantiated by the parent, not inside this block.
- One sub-module is natural: `serial_shift_reg` (parameterised WIDTH, load/shift/serial-in). It is used for A, B and the result.

## Test plan
- ADD 5 + 3 → `rsp_result`=8, zero=0, carry=0, ovf=0; `rsp_valid` exactly 33 cycles after accept.
- SUB 3 − 5 → 0xFFFFFFFE, carry=0, ovf=0. ADD 0x7FFFFFFF + 1 → 0x80000000, ovf=1.
- SLT 0x80000000 vs 1 → 1 (ovf=1 path); SLT 2 vs −7 (0xFFFFFFF9) → 0. Latency is 34 for both.
- AND / OR / NOR with A=0xF0F0F0F0, B=0xFF00FF00 → 0xF000F000 / 0xFFF0FFF0 / 0x000F000F. Op 4 → 0, zero=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles → outputs stable and `req_ready`=0; then a new request is accepted 1 cycle after the handshake.
- Assert `rst_n` low at RUN `idx`=17 → `rsp_valid` never rises; after release `req_ready`=1 and a fresh ADD completes correctly.

Source files
------------

// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states
// and op-class helpers.
package alu_serial_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ops whose carry and overflow flags are meaningful.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic is_supported(input logic [3:0] op);
    return is_arith(op) || (op == ALU_AND) || (op == ALU_OR) || (op == ALU_NOR);
  endfunction

endpackage

// File: rtl/alu_serial_seq_shift_reg.sv
// WIDTH-bit right-shift register with parallel load (priority) and serial
// input at the MSB.
module alu_serial_seq_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (shift) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds an external one-bit slice LSB-first, keeps
// the ripple carry in a flop and fixes up SLT after the MSB.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic [3:0]       alu_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_less,
  output logic             alu_sub,
  input  logic             alu_r,
  input  logic             alu_cout,
  input  logic             alu_set
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             ovf_q;
  logic             set_q;
  logic             zero_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_load;
  logic [WIDTH-1:0] result_shifted;
  logic             accept;
  logic             running;
  logic             fixing;
  logic             sub_op;
  logic             arith_op;
  logic             res_in;
  logic             unused_bits;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign running  = (state_q == ST_RUN);
  assign fixing   = (state_q == ST_FIX);
  assign sub_op   = (op_q == ALU_SUB) || (op_q == ALU_SLT);
  assign arith_op = is_arith(op_q);

  // Unsupported ops shift in zeros so the result ends up forced to 0.
  assign res_in         = is_supported(op_q) & alu_r;
  assign result_shifted = {res_in, result_q[WIDTH-1:1]};
  assign result_load    = accept ? '0 : {{(WIDTH-1){1'b0}}, set_q ^ ovf_q};

  alu_serial_seq_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (req_a),
    .shift      (running),
    .serial_in  (1'b0),
    .q          (a_q)
  );

  alu_serial_seq_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (req_b),
    .shift      (running),
    .serial_in  (1'b0),
    .q          (b_q)
  );

  alu_serial_seq_shift_reg #(.WIDTH(WIDTH)) u_result_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept || fixing),
    .load_value (result_load),
    .shift      (running),
    .serial_in  (res_in),
    .q          (result_q)
  );

  // Only the LSBs of the operand shifters feed the slice.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  assign alu_op   = op_q;
  assign alu_a    = running & a_q[0];
  assign alu_b    = running & b_q[0];
  assign alu_sub  = running & sub_op;
  assign alu_cin  = running & ((idx_q == '0) ? sub_op : carry_q);
  assign alu_less = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      set_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            set_q   <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry_q <= alu_cout;
          if (idx_q == LAST_IDX) begin
            set_q   <= alu_set;
            ovf_q   <= arith_op & (alu_cin ^ alu_cout);
            carry_q <= arith_op & alu_cout;
            if (op_q == ALU_SLT) begin
              state_q <= ST_FIX;
            end else begin
              zero_q  <= (result_shifted == '0);
              state_q <= ST_DONE;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_FIX: begin
          zero_q  <= ~(set_q ^ ovf_q);
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_carry  = carry_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq: behavioural one-bit slice, word-level result
// model with a response scoreboard, and directed request vectors.
module tb_alu_serial_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_carry;
  logic         rsp_ovf;
  logic [3:0]   alu_op;
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic         alu_less;
  logic         alu_sub;
  logic         alu_r;
  logic         alu_cout;
  logic         alu_set;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [3:0] last_op;
  int         checks;
  int         passed;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_less   (alu_less),
    .alu_sub    (alu_sub),
    .alu_r      (alu_r),
    .alu_cout   (alu_cout),
    .alu_set    (alu_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-bit slice; unsupported ops deliberately return a nonzero bit.
  logic slice_bi;
  logic slice_sum;
  always_comb begin
    slice_bi  = alu_sub ? ~alu_b : alu_b;
    slice_sum = alu_a ^ slice_bi ^ alu_cin;
    alu_cout  = (alu_a & slice_bi) | (alu_a & alu_cin) | (slice_bi & alu_cin);
    alu_set   = slice_sum;
    case (alu_op)
      OP_AND:         alu_r = alu_a & alu_b;
      OP_OR:          alu_r = alu_a | alu_b;
      OP_ADD, OP_SUB: alu_r = slice_sum;
      OP_SLT:         alu_r = alu_less;
      OP_NOR:         alu_r = ~(alu_a | alu_b);
      default:        alu_r = alu_a | alu_b;
    endcase
  end

  function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t       r;
    logic [W:0] s;
    r = '0;
    s = '0;
    case (op)
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_NOR: r.result = ~(a | b);
      OP_ADD: begin
        s        = {1'b0, a} + {1'b0, b};
        r.result = s[W-1:0];
        r.carry  = s[W];
        r.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      OP_SUB, OP_SLT: begin
        s        = {1'b0, a} + {1'b0, ~b} + 1;
        r.carry  = s[W];
        r.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        r.result = (op == OP_SLT) ? W'($signed(a) < $signed(b)) : s[W-1:0];
      end
      default: r.result = '0;
    endcase
    r.zero = (r.result == '0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Scoreboard compare: every cycle out of reset, checked on the falling edge.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q[0];
            checkOutput("rsp_result", 64'(rsp_result), 64'(e.result));
            checkOutput("rsp_zero", 64'(rsp_zero), 64'(e.zero));
            checkOutput("rsp_carry", 64'(rsp_carry), 64'(e.carry));
            checkOutput("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
            checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
            if (rsp_ready) void'(exp_q.pop_front());
          end
        end
        if (req_ready || rsp_valid)
          checkOutput("alu_idle", 64'({alu_a, alu_b, alu_cin, alu_less, alu_sub}), 64'd0);
        checkOutput("alu_op", 64'(alu_op), 64'(last_op));
      end
    end
  end

  task automatic sendReq(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready && waited < 200);
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    last_op = op;
    #1;
    req_valid = 1'b0;
  endtask

  task automatic awaitRsp(input int exp_lat, input int hold, input bit preready);
    int lat;
    rsp_ready = preready;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    if (!preready) begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int hold, input bit preready, output int waited);
    sendReq(op, a, b, waited);
    awaitRsp((op == OP_SLT) ? W + 2 : W + 1, hold, preready);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    checkOutput({tag, "_flags"}, 64'({rsp_zero, rsp_carry, rsp_ovf}), 64'd0);
    checkOutput({tag, "_alu"}, 64'({alu_op, alu_a, alu_b, alu_cin, alu_less, alu_sub}), 64'd0);
  endtask

  initial begin
    int   waited;
    int   seen;
    rsp_t m;

    checks    = 0;
    passed    = 0;
    last_op   = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    @(negedge clk);
    checkResetState("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkResetState("post_reset");

    // Hand-computed values that pin the word-level model.
    m = model(OP_ADD, 32'd5, 32'd3);
    checkOutput("pin_add", 64'({m.result, m.zero, m.carry, m.ovf}), {29'd0, 32'd8, 3'b000});
    m = model(OP_SUB, 32'd3, 32'd5);
    checkOutput("pin_sub", 64'({m.result, m.zero, m.carry, m.ovf}), {29'd0, 32'hFFFF_FFFE, 3'b000});
    m = model(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    checkOutput("pin_add_ovf", 64'({m.result, m.ovf}), {31'd0, 32'h8000_0000, 1'b1});
    m = model(OP_SLT, 32'h8000_0000, 32'd1);
    checkOutput("pin_slt_ovf", 64'({m.result, m.ovf}), {31'd0, 32'd1, 1'b1});
    m = model(OP_SLT, 32'd2, 32'hFFFF_FFF9);
    checkOutput("pin_slt_neg", 64'({m.result, m.zero}), {31'd0, 32'd0, 1'b1});
    m = model(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOutput("pin_and", 64'(m.result), 64'h0000_0000_F000_F000);
    m = model(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOutput("pin_or", 64'(m.result), 64'h0000_0000_FFF0_FFF0);
    m = model(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOutput("pin_nor", 64'(m.result), 64'h0000_0000_000F_000F);
    m = model(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkOutput("pin_op4", 64'({m.result, m.zero}), {31'd0, 32'd0, 1'b1});

    applyStimulus(OP_ADD, 32'd5, 32'd3, 0, 1'b0, waited);
    applyStimulus(OP_SUB, 32'd3, 32'd5, 0, 1'b0, waited);
    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, waited);
    applyStimulus(OP_SLT, 32'h8000_0000, 32'd1, 0, 1'b0, waited);
    applyStimulus(OP_SLT, 32'd2, 32'hFFFF_FFF9, 0, 1'b0, waited);
    applyStimulus(OP_SLT, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, waited);
    applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, waited);
    applyStimulus(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, waited);
    applyStimulus(OP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, waited);
    applyStimulus(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0, waited);
    applyStimulus(OP_SUB, 32'd9, 32'd9, 0, 1'b1, waited);

    // Backpressure, then a request accepted on the cycle right after the handshake.
    applyStimulus(OP_ADD, 32'h1234_5678, 32'h0FED_CBA9, 10, 1'b0, waited);
    applyStimulus(OP_SUB, 32'h8000_0000, 32'd1, 0, 1'b0, waited);
    checkOutput("next_accept_wait", 64'(waited), 64'd1);

    // Abort a request partway through RUN with reset.
    sendReq(OP_ADD, 32'hFFFF_FFFF, 32'd1, waited);
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    last_op = '0;
    #1 checkResetState("abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("abort_no_rsp", 64'(seen), 64'd0);
    checkOutput("abort_req_ready", 64'(req_ready), 64'd1);
    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, waited);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
